haar_pair_filter: RTL and testbench
===================================

# haar_pair_filter

Streaming, parametrised 1-D Haar analysis stage for the 2D-DWT image compression datapath. It accepts one pixel per cycle on a valid/ready stream and pairs consecutive samples (even, odd). For each pair it emits a low-pass coefficient (pair average) and a high-pass coefficient (half difference) on a registered valid/ready output. It replaces the single-pair, unsigned-only half-difference stage: it adds signed detail output, back-pressure and row tracking, and runs once per row/column pass of the transform.

## Interface
- DATA_W, 8, pixel width in bits (≥2)
- ROW_LEN, 8, samples per row; must be even and ≥2; checked at elaboration
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts a sample this cycle
- s_data  in  DATA_W  unsigned input sample
- m_valid  out  1  output coefficient pair valid
- m_ready  in  1  downstream accepts output
- m_low  out  DATA_W  unsigned low-pass coefficient
- m_high  out  DATA_W+1  two's-complement high-pass coefficient
- m_last  out  1  output pair is the last pair of a row

## Operation
- Input transfer occurs when s_valid && s_ready. Output transfer occurs when m_valid && m_ready.
- Two-state FSM:
  - EVEN: a transfer stores s_data in hold register `a`, then the FSM goes to ODD.
  - ODD: a transfer takes s_data as `b`, loads the output register, then the FSM goes to EVEN.
- s_ready = (state==EVEN) || !m_valid || m_ready. EVEN is always ready because the hold register is free in that state.
- Low-pass: m_low = (a + b) >> 1. The sum is formed in DATA_W+1 bits and truncated (floor).
- High-pass: d = a − b in DATA_W+1 signed; m_high = d >>> 1, an arithmetic shift (floor toward −∞).
- Pair counter: range 0..ROW_LEN/2−1. It increments on every pair loaded into the output register and wraps to 0 after ROW_LEN/2−1.
- m_last = 1 when the loaded pair index equals ROW_LEN/2−1.
- The output register holds m_low, m_high and m_last stable while m_valid && !m_ready.
- m_valid clears on an output transfer unless a new pair loads in the same cycle.
- Simultaneous output transfer and new pair load: the new pair wins and m_valid stays 1.

## Timing
- Reset values: m_valid=0, m_low=0, m_high=0, m_last=0, state=EVEN, hold register=0, pair counter=0. s_ready reads 1 while in reset.
- Latency: m_valid rises on the clock edge that accepts the odd sample. Outputs are visible the cycle after that edge.
- Throughput: 1 sample/cycle sustained with m_ready=1, i.e. one pair per 2 cycles.
- Back-pressure: with m_valid=1 and m_ready=0, the even sample of the next pair is still accepted. s_ready drops only in ODD, and the odd sample then waits.
- Reset asserted mid-pair: a pending even sample is discarded, any unconsumed output is dropped, and the row position restarts at pair 0.
- No combinational path from s_valid to m_valid. m_ready → s_ready is combinational.

## Configuration
- HAAR_ABS_HIGH_EN:
  - Defined: m_high = |a − b| >> 1, zero-extended to DATA_W+1 bits (MSB always 0). This is the legacy unsigned half-difference behaviour.
  - Undefined (default): signed arithmetic-shift result as specified in Operation.
  - Low-pass path, handshake and timing are identical in both builds.

## Test plan
- Single pair, default build, DATA_W=8: s_data 3 then 10 → m_low=6, m_high=9'h1FC (−4), m_last=0. With HAAR_ABS_HIGH_EN: m_high=3.
- Extremes: 255,0 → m_low=127, m_high=127. 0,255 → m_low=127, m_high=9'h180 (−128).
- Streaming, ROW_LEN=8, m_ready=1, 16 samples back-to-back → s_ready stays 1, 8 outputs arrive at one per 2 cycles, m_last=1 on output pairs 3 and 7 only.
- Back-pressure: m_ready=0 after the first output. The even sample is accepted, s_ready=0 in ODD, and the first output holds stable. Raising m_ready for 1 cycle transfers it and accepts the odd sample in the same cycle; m_valid stays 1 with the new pair.
- Reset mid-pair: accept 7, assert reset for 1 cycle, then send 20,4 → output m_low=12, m_high=8 with pair index 0 (m_last=0). The 7 never appears in any output.
- Reset while m_valid=1 && m_ready=0 → m_valid=0 immediately (asynchronous), all outputs 0.

Source files
------------

// File: rtl/haar_pair_filter.sv
// Streaming 1-D Haar analysis stage: pairs consecutive samples into low-pass (average) and high-pass (half difference) coefficients.
// Define HAAR_ABS_HIGH_EN for the legacy unsigned |a-b|>>1 high-pass output; the default build emits the signed a-b>>>1 result.
module haar_pair_filter #(
    parameter int DATA_W  = 8,
    parameter int ROW_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_low,
    output logic [DATA_W:0]   m_high,
    output logic              m_last
);

    localparam int PAIRS = ROW_LEN / 2;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

    generate
        if (DATA_W < 2) begin : g_bad_data_w
            $error("haar_pair_filter: DATA_W must be >= 2");
        end
        if ((ROW_LEN < 2) || (ROW_LEN % 2 != 0)) begin : g_bad_row_len
            $error("haar_pair_filter: ROW_LEN must be even and >= 2");
        end
    endgenerate

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  a;
    logic [CNT_W-1:0]   pair_cnt;

    logic               load;
    logic [DATA_W:0]    sum;
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0]  low_next;
    logic [DATA_W:0]    high_next;
`ifdef HAAR_ABS_HIGH_EN
    logic [DATA_W:0]    mag;
`endif

    // The hold register is free in EVEN, so only the odd sample can stall.
    assign s_ready = (state == EVEN) || !m_valid || m_ready;
    assign load    = s_valid && s_ready && (state == ODD);

    // NOTE: combinational logic uses blocking '=' with every output assigned
    // up front, so no latch is inferred; clocked state below uses '<=' only.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, s_data};
        diff     = $signed({1'b0, a}) - $signed({1'b0, s_data});
        low_next = DATA_W'(sum >> 1);
`ifdef HAAR_ABS_HIGH_EN
        mag       = (diff < 0) ? -diff : diff;
        high_next = mag >> 1;
`else
        high_next = diff >>> 1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EVEN;
            a        <= '0;
            pair_cnt <= '0;
            m_valid  <= 1'b0;
            m_low    <= '0;
            m_high   <= '0;
            m_last   <= 1'b0;
        end else begin
            if (s_valid && s_ready && (state == EVEN)) begin
                a     <= s_data;
                state <= ODD;
            end

            // A new pair takes priority over clearing a consumed output.
            if (load) begin
                state    <= EVEN;
                m_valid  <= 1'b1;
                m_low    <= low_next;
                m_high   <= high_next;
                m_last   <= (pair_cnt == LAST_PAIR);
                pair_cnt <= (pair_cnt == LAST_PAIR) ? '0 : pair_cnt + CNT_W'(1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_haar_pair_filter.sv
// Directed self-checking bench for haar_pair_filter (DATA_W=8, ROW_LEN=8).
// Expected high-pass values follow HAAR_ABS_HIGH_EN when it is defined for the build.
module tb_haar_pair_filter;

    localparam int DATA_W  = 8;
    localparam int ROW_LEN = 8;

    logic              clk;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_low;
    logic [DATA_W:0]   m_high;
    logic              m_last;

    int total;
    int bad;

    haar_pair_filter #(
        .DATA_W (DATA_W),
        .ROW_LEN(ROW_LEN)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_low  (m_low),
        .m_high (m_high),
        .m_last (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] even;
        logic [7:0] odd;
        logic [7:0] low;
        logic [8:0] high_s;
        logic [8:0] high_a;
        logic       last;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [8:0] pick_high(input logic [8:0] hs, input logic [8:0] ha);
`ifdef HAAR_ABS_HIGH_EN
        return ha;
`else
        return hs;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one pair back-to-back with m_ready=1 and checks the loaded output.
    task automatic send_pair(input string name, input logic [7:0] ev, input logic [7:0] od,
                             input logic [7:0] lo, input logic [8:0] hs, input logic [8:0] ha,
                             input logic last);
        s_valid = 1'b1;
        s_data  = ev;
        tick();
        s_data = od;
        tick();
        s_valid = 1'b0;
        check({name, "_valid"}, 32'(m_valid), 32'd1);
        check({name, "_low"},   32'(m_low),   32'(lo));
        check({name, "_high"},  32'(m_high),  32'(pick_high(hs, ha)));
        check({name, "_last"},  32'(m_last),  32'(last));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;

        tbl[0] = '{8'd3,   8'd10,  8'd6,   9'h1FC, 9'h003, 1'b0};
        tbl[1] = '{8'd255, 8'd0,   8'd127, 9'h07F, 9'h07F, 1'b0};
        tbl[2] = '{8'd0,   8'd255, 8'd127, 9'h180, 9'h07F, 1'b0};
        tbl[3] = '{8'd100, 8'd50,  8'd75,  9'h019, 9'h019, 1'b1};
        tbl[4] = '{8'd7,   8'd8,   8'd7,   9'h1FF, 9'h000, 1'b0};
        tbl[5] = '{8'd8,   8'd7,   8'd7,   9'h000, 9'h000, 1'b0};
        tbl[6] = '{8'd200, 8'd201, 8'd200, 9'h1FF, 9'h000, 1'b0};
        tbl[7] = '{8'd255, 8'd255, 8'd255, 9'h000, 9'h000, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  32'(m_valid), 32'd0);
        check("rst_low",    32'(m_low),   32'd0);
        check("rst_high",   32'(m_high),  32'd0);
        check("rst_last",   32'(m_last),  32'd0);
        check("rst_sready", 32'(s_ready), 32'd1);
        reset = 1'b0;
        tick();

        // One full row streamed back-to-back with m_ready=1.
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = (i % 2 == 0) ? tbl[i / 2].even : tbl[i / 2].odd;
            check($sformatf("stream_sready_%0d", i), 32'(s_ready), 32'd1);
            tick();
            if (i % 2 == 1) begin
                check($sformatf("stream_valid_%0d", i / 2), 32'(m_valid), 32'd1);
                check($sformatf("stream_low_%0d", i / 2),   32'(m_low),   32'(tbl[i / 2].low));
                check($sformatf("stream_high_%0d", i / 2),  32'(m_high),
                      32'(pick_high(tbl[i / 2].high_s, tbl[i / 2].high_a)));
                check($sformatf("stream_last_%0d", i / 2),  32'(m_last),  32'(tbl[i / 2].last));
            end else if (i > 0) begin
                check($sformatf("stream_gap_%0d", i / 2), 32'(m_valid), 32'd0);
            end
        end
        s_valid = 1'b0;
        tick();
        check("stream_drain", 32'(m_valid), 32'd0);

        // Back-pressure: first output held while the next pair waits in ODD.
        send_pair("bp_first", 8'd3, 8'd10, 8'd6, 9'h1FC, 9'h003, 1'b0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'd20;
        check("bp_even_ready", 32'(s_ready), 32'd1);
        tick();
        s_data = 8'd4;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bp_odd_stall_%0d", k), 32'(s_ready), 32'd0);
            check($sformatf("bp_hold_valid_%0d", k), 32'(m_valid), 32'd1);
            check($sformatf("bp_hold_low_%0d", k), 32'(m_low), 32'd6);
            check($sformatf("bp_hold_high_%0d", k), 32'(m_high), 32'(pick_high(9'h1FC, 9'h003)));
            tick();
        end
        m_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("bp_new_valid", 32'(m_valid), 32'd1);
        check("bp_new_low",   32'(m_low),   32'd12);
        check("bp_new_high",  32'(m_high),  32'd8);
        check("bp_new_last",  32'(m_last),  32'd0);
        tick();
        check("bp_drain", 32'(m_valid), 32'd0);

        // Reset mid-pair: the pending 7 is discarded and the row restarts.
        s_valid = 1'b1;
        s_data  = 8'd7;
        tick();
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        send_pair("mid_p0", 8'd20, 8'd4, 8'd12, 9'h008, 9'h008, 1'b0);
        send_pair("mid_p1", 8'd1,  8'd2, 8'd1,  9'h1FF, 9'h000, 1'b0);
        send_pair("mid_p2", 8'd2,  8'd2, 8'd2,  9'h000, 9'h000, 1'b0);
        send_pair("mid_p3", 8'd9,  8'd4, 8'd6,  9'h002, 9'h002, 1'b1);
        tick();

        // Asynchronous reset while an output is stalled.
        send_pair("arst_pair", 8'd50, 8'd10, 8'd30, 9'h014, 9'h014, 1'b0);
        m_ready = 1'b0;
        tick();
        check("arst_pre_valid", 32'(m_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_low",   32'(m_low),   32'd0);
        check("arst_high",  32'(m_high),  32'd0);
        check("arst_last",  32'(m_last),  32'd0);
        check("arst_sready", 32'(s_ready), 32'd1);
        tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
